culsans_axi_sram_slave: RTL and testbench

AXI/ACE subordinate that terminates one crossbar master port with an internal 64-bit-wide memory array. It is the responder end of the `culsans_pkg` slave-side channel structs (`req_slv_t` / `resp_slv_t`). It serves one transaction at a time: AR, then R beats; or AW, then W beats, then B. It is used as the shared-DRAM model behind the crossbar in simulation and in FPGA builds without DDR. ACE snoop, barrier and domain fields are accepted and ignored.

---
 rtl/culsans_pkg.sv | 86 ++++++++
 rtl/culsans_axi_sram_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_culsans_axi_sram_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/culsans_pkg.sv
// Channel structs for the slave (subordinate) side of the Culsans crossbar.
// Carries the AXI5 atop plus ACE snoop/barrier/domain fields.
package culsans_pkg;

    localparam logic [63:0] DRAMBase   = 64'h8000_0000;
    localparam int unsigned IdWidthSlv = 4;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [63:0]           addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic                  user;
        logic [2:0]            snoop;
        logic [1:0]            bar;
        logic [1:0]            domain;
        logic                  awunique;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [1:0]            resp;
        logic                  user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [63:0]           addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic                  user;
        logic [3:0]            snoop;
        logic [1:0]            bar;
        logic [1:0]            domain;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidthSlv-1:0] id;
        logic [63:0]           data;
        logic [3:0]            resp;
        logic                  last;
        logic                  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_slv_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_slv_t;

endpackage

// File: rtl/culsans_axi_sram_slave.sv
// AXI/ACE subordinate backed by a 64-bit word array; serves one transaction at a time.
// Define CULSANS_SRAM_EXCL_EN to add exclusive-access support with a single reservation.
module culsans_axi_sram_slave #(
    parameter int unsigned MemWords = 4096,
    parameter logic [63:0] BaseAddr = culsans_pkg::DRAMBase
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  culsans_pkg::req_slv_t  req_i,
    output culsans_pkg::resp_slv_t resp_o
);
    localparam int unsigned IdW        = culsans_pkg::IdWidthSlv;
    localparam int unsigned IdxW       = $clog2(MemWords);
    localparam logic [63:0] MemBytes   = 64'(MemWords) << 3;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespExOkay = 2'b01;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] id_q, id_d;
    logic [63:0]    addr_q, addr_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [2:0]     size_q, size_d;
    logic [1:0]     burst_q, burst_d;
    logic           lock_q, lock_d;
    logic           rr_q, rr_d;
    logic           err_q, err_d;
    logic           atop_q, atop_d;
    logic           excl_ok_q, excl_ok_d;

    logic            pick_read, ar_hs, aw_hs, mem_we, in_range;
    logic            excl_match, excl_wr;
    logic [63:0]     off, rd_word;
    logic [IdxW-1:0] idx;
    logic [1:0]      rresp, bresp;
    logic            unused_ok;

    function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [1:0] burst,
                                              input logic [2:0] size, input logic [7:0] len);
        logic [63:0] step, mask;
        step = 64'd1 << size;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
            default: next_addr = a + step;
        endcase
    endfunction

`ifdef CULSANS_SRAM_EXCL_EN
    localparam bit ExclEn = 1'b1;

    logic           resv_valid_q, resv_valid_d;
    logic [IdW-1:0] resv_id_q, resv_id_d;
    logic [57:0]    resv_line_q, resv_line_d;

    assign excl_match = resv_valid_q && (resv_id_q == req_i.aw.id) &&
                        (resv_line_q == req_i.aw.addr[63:6]);

    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_id_d    = resv_id_q;
        resv_line_d  = resv_line_q;
        if (ar_hs && req_i.ar.lock) begin
            resv_valid_d = 1'b1;
            resv_id_d    = req_i.ar.id;
            resv_line_d  = req_i.ar.addr[63:6];
        end
        // A successful exclusive store consumes the reservation; a plain store to the line kills it.
        if (aw_hs && req_i.aw.lock && excl_match && (req_i.aw.atop == 6'd0))
            resv_valid_d = 1'b0;
        if (mem_we && !lock_q && (addr_q[63:6] == resv_line_q))
            resv_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resv_valid_q <= 1'b0;
            resv_id_q    <= '0;
            resv_line_q  <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_id_q    <= resv_id_d;
            resv_line_q  <= resv_line_d;
        end
    end
`else
    localparam bit ExclEn = 1'b0;

    assign excl_match = 1'b0;
`endif

    assign excl_wr   = ExclEn && lock_q;
    assign unused_ok = ^{req_i, lock_q};

    always_comb begin
        pick_read = req_i.ar_valid && (!req_i.aw_valid || !rr_q);
        ar_hs     = (state_q == IDLE) && pick_read;
        aw_hs     = (state_q == IDLE) && req_i.aw_valid && !pick_read;
        off       = addr_q - BaseAddr;
        in_range  = off < MemBytes;
        idx       = off[3 +: IdxW];
        mem_we    = (state_q == WRITE) && req_i.w_valid && in_range && !atop_q &&
                    (!excl_wr || excl_ok_q);
        rresp     = !in_range ? RespSlvErr : (excl_wr ? RespExOkay : RespOkay);
        bresp     = err_q ? RespSlvErr : ((excl_wr && excl_ok_q) ? RespExOkay : RespOkay);
    end

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] lane_q [MemWords];

        always_ff @(posedge clk_i) begin
            if (mem_we && req_i.w.strb[gi])
                lane_q[idx] <= req_i.w.data[gi*8 +: 8];
        end

        assign rd_word[gi*8 +: 8] = lane_q[idx];
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        lock_d    = lock_q;
        rr_d      = rr_q;
        err_d     = err_q;
        atop_d    = atop_q;
        excl_ok_d = excl_ok_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d    = req_i.ar.id;
                    addr_d  = req_i.ar.addr;
                    len_d   = req_i.ar.len;
                    cnt_d   = req_i.ar.len;
                    size_d  = req_i.ar.size;
                    burst_d = req_i.ar.burst;
                    lock_d  = req_i.ar.lock;
                    state_d = READ;
                    // Round-robin only flips when both channels actually contended.
                    if (req_i.aw_valid) rr_d = 1'b1;
                end else if (aw_hs) begin
                    id_d      = req_i.aw.id;
                    addr_d    = req_i.aw.addr;
                    len_d     = req_i.aw.len;
                    cnt_d     = req_i.aw.len;
                    size_d    = req_i.aw.size;
                    burst_d   = req_i.aw.burst;
                    lock_d    = req_i.aw.lock;
                    atop_d    = |req_i.aw.atop;
                    err_d     = |req_i.aw.atop;
                    excl_ok_d = req_i.aw.lock && excl_match;
                    state_d   = WRITE;
                    if (req_i.ar_valid) rr_d = 1'b0;
                end
            end
            READ: begin
                if (req_i.r_ready) begin
                    addr_d = next_addr(addr_q, burst_q, size_q, len_q);
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) state_d = IDLE;
                end
            end
            WRITE: begin
                if (req_i.w_valid) begin
                    addr_d = next_addr(addr_q, burst_q, size_q, len_q);
                    if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                    if (!in_range || (req_i.w.last != (cnt_q == 8'd0))) err_d = 1'b1;
                    if (req_i.w.last) state_d = WRESP;
                end
            end
            WRESP: begin
                if (req_i.b_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            lock_q    <= 1'b0;
            rr_q      <= 1'b0;
            err_q     <= 1'b0;
            atop_q    <= 1'b0;
            excl_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            lock_q    <= lock_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
            atop_q    <= atop_d;
            excl_ok_q <= excl_ok_d;
        end
    end

    // Payloads are forced to zero outside their valid state so reset leaves them clean.
    always_comb begin
        resp_o          = '0;
        resp_o.ar_ready = ar_hs;
        resp_o.aw_ready = aw_hs;
        resp_o.w_ready  = (state_q == WRITE);
        if (state_q == READ) begin
            resp_o.r_valid = 1'b1;
            resp_o.r.id    = id_q;
            resp_o.r.data  = in_range ? rd_word : 64'd0;
            resp_o.r.resp  = {2'b00, rresp};
            resp_o.r.last  = (cnt_q == 8'd0);
        end
        if (state_q == WRESP) begin
            resp_o.b_valid = 1'b1;
            resp_o.b.id    = id_q;
            resp_o.b.resp  = bresp;
        end
    end

endmodule

// File: tb/tb_culsans_axi_sram_slave.sv
// Directed scoreboard bench for culsans_axi_sram_slave (default MemWords/BaseAddr).
module tb_culsans_axi_sram_slave;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    logic clk = 1'b0;
    logic rst;
    culsans_pkg::req_slv_t  req;
    culsans_pkg::resp_slv_t resp;

    r_exp_t r_q[$];
    b_exp_t b_q[$];
    int compared   = 0;
    int mismatched = 0;
    logic [63:0] wd [4];
    logic [63:0] ed [4];

    culsans_axi_sram_slave dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .resp_o (resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic lock);
        req.ar       = '0;
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = 3'd3;
        req.ar.burst = burst;
        req.ar.lock  = lock;
        req.ar_valid = 1'b1;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic lock, input logic [5:0] atop);
        req.aw       = '0;
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = 3'd3;
        req.aw.burst = burst;
        req.aw.lock  = lock;
        req.aw.atop  = atop;
        req.aw_valid = 1'b1;
    endtask

    task automatic wait_ar(input bit strict);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (strict && c == 0) check("ar_ready_prompt", resp.ar_ready, 1);
            if (resp.ar_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req.ar_valid = 1'b0;
        check("ar_handshake", ok, 1);
    endtask

    task automatic wait_aw(input bit strict);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (strict && c == 0) check("aw_ready_prompt", resp.aw_ready, 1);
            if (resp.aw_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req.aw_valid = 1'b0;
        check("aw_handshake", ok, 1);
    endtask

    task automatic write_data(input logic [63:0] d [4], input int n, input logic [7:0] strb);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok          = 1'b0;
            req.w.data  = d[i];
            req.w.strb  = strb;
            req.w.last  = (i == n - 1);
            req.w_valid = 1'b1;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                if (c == 0) check("w_ready_prompt", resp.w_ready, 1);
                if (resp.w_ready) ok = 1'b1;
                @(posedge clk); #1;
            end
            check("w_handshake", ok, 1);
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
    endtask

    task automatic recv_b();
        b_exp_t e;
        bit ok;
        ok          = 1'b0;
        req.b_ready = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (c == 0) check("b_valid_prompt", resp.b_valid, 1);
            if (resp.b_valid) begin
                ok = 1'b1;
                e  = b_q.pop_front();
                check("b_id", resp.b.id, e.id);
                check("b_resp", resp.b.resp, e.resp);
            end
            @(posedge clk); #1;
        end
        req.b_ready = 1'b0;
        check("b_handshake", ok, 1);
    endtask

    task automatic recv_r(input int n, input bit toggle);
        r_exp_t e;
        int got;
        int cyc;
        got         = 0;
        cyc         = 0;
        req.r_ready = 1'b1;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0) check("r_valid_latency", resp.r_valid, 1);
            if (resp.r_valid && req.r_ready) begin
                e = r_q.pop_front();
                check("r_data", resp.r.data, e.data);
                check("r_resp", resp.r.resp, e.resp);
                check("r_last", resp.r.last, e.last);
                check("r_id", resp.r.id, e.id);
                got++;
            end else if (resp.r_valid && r_q.size() > 0) begin
                check("r_hold_data", resp.r.data, r_q[0].data);
            end
            @(posedge clk); #1;
            cyc++;
            if (toggle) req.r_ready = !req.r_ready;
        end
        req.r_ready = 1'b0;
        check("r_beat_count", got, n);
    endtask

    task automatic push_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] rsp,
                          input logic last);
        r_exp_t e;
        e.id   = id;
        e.data = data;
        e.resp = {2'b00, rsp};
        e.last = last;
        r_q.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] rsp);
        b_exp_t e;
        e.id   = id;
        e.resp = rsp;
        b_q.push_back(e);
    endtask

    task automatic write_txn(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic lock, input logic [5:0] atop,
                             input logic [63:0] d [4], input int n, input logic [7:0] strb,
                             input logic [1:0] exp_resp);
        push_b(id, exp_resp);
        drive_aw(id, addr, len, burst, lock, atop);
        wait_aw(1);
        write_data(d, n, strb);
        recv_b();
    endtask

    task automatic read_txn(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic lock, input logic [63:0] exp [4],
                            input logic [1:0] exp_resp, input bit toggle);
        for (int i = 0; i <= int'(len); i++) push_r(id, exp[i], exp_resp, i == int'(len));
        drive_ar(id, addr, len, burst, lock);
        wait_ar(1);
        recv_r(int'(len) + 1, toggle);
    endtask

    initial begin
        req = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ar_ready", resp.ar_ready, 0);
        check("rst_aw_ready", resp.aw_ready, 0);
        check("rst_w_ready", resp.w_ready, 0);
        check("rst_r_valid", resp.r_valid, 0);
        check("rst_b_valid", resp.b_valid, 0);
        check("rst_r_payload", {resp.r.data, resp.r.resp, resp.r.last}, 0);
        check("rst_b_payload", {resp.b.id, resp.b.resp}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write then read back.
        wd[0] = 64'hDEAD_BEEF_0123_4567;
        write_txn(4'd5, 64'h8000_0008, 8'd0, INCR, 1'b0, 6'd0, wd, 1, 8'hFF, OKAY);
        ed[0] = 64'hDEAD_BEEF_0123_4567;
        read_txn(4'd6, 64'h8000_0008, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);

        // INCR burst, read back with r_ready toggling.
        wd = '{64'd1, 64'd2, 64'd3, 64'd4};
        write_txn(4'd1, 64'h8000_0100, 8'd3, INCR, 1'b0, 6'd0, wd, 4, 8'hFF, OKAY);
        ed = '{64'd1, 64'd2, 64'd3, 64'd4};
        read_txn(4'd2, 64'h8000_0100, 8'd3, INCR, 1'b0, ed, OKAY, 1'b1);

        // WRAP read starting mid-block.
        ed = '{64'd4, 64'd1, 64'd2, 64'd3};
        read_txn(4'd9, 64'h8000_0118, 8'd3, WRAP, 1'b0, ed, OKAY, 1'b0);

        // Partial strobe over an all-ones word.
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        write_txn(4'd2, 64'h8000_0140, 8'd0, INCR, 1'b0, 6'd0, wd, 1, 8'hFF, OKAY);
        wd[0] = 64'd0;
        write_txn(4'd2, 64'h8000_0140, 8'd0, FIXED, 1'b0, 6'd0, wd, 1, 8'h0F, OKAY);
        ed[0] = 64'hFFFF_FFFF_0000_0000;
        read_txn(4'd3, 64'h8000_0140, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);

        // Out-of-range accesses; word 0 is the aliasing word and must not change.
        wd[0] = 64'hA5A5_A5A5_A5A5_A5A5;
        write_txn(4'd4, 64'h8000_0000, 8'd0, INCR, 1'b0, 6'd0, wd, 1, 8'hFF, OKAY);
        ed[0] = 64'd0;
        read_txn(4'd4, 64'h8000_8000, 8'd0, INCR, 1'b0, ed, SLVERR, 1'b0);
        wd[0] = 64'h1234_5678_9ABC_DEF0;
        write_txn(4'd4, 64'h8000_8000, 8'd0, INCR, 1'b0, 6'd0, wd, 1, 8'hFF, SLVERR);
        ed[0] = 64'hA5A5_A5A5_A5A5_A5A5;
        read_txn(4'd4, 64'h8000_0000, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);

        // Atomic write: data consumed, array untouched, SLVERR.
        wd[0] = 64'd0;
        write_txn(4'd7, 64'h8000_0008, 8'd0, INCR, 1'b0, 6'h20, wd, 1, 8'hFF, SLVERR);
        ed[0] = 64'hDEAD_BEEF_0123_4567;
        read_txn(4'd7, 64'h8000_0008, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);

        // Early w.last: written beat stays, response is SLVERR.
        wd[0] = 64'h77;
        write_txn(4'd8, 64'h8000_01C0, 8'd1, INCR, 1'b0, 6'd0, wd, 1, 8'hFF, SLVERR);
        ed[0] = 64'h77;
        read_txn(4'd8, 64'h8000_01C0, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);

        // Arbitration from reset: read first, then the next contended pair goes write first.
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        push_r(4'd1, 64'hDEAD_BEEF_0123_4567, OKAY, 1'b1);
        push_b(4'd2, OKAY);
        drive_ar(4'd1, 64'h8000_0008, 8'd0, INCR, 1'b0);
        drive_aw(4'd2, 64'h8000_0180, 8'd0, INCR, 1'b0, 6'd0);
        @(negedge clk);
        check("arb1_ar_ready", resp.ar_ready, 1);
        check("arb1_aw_ready", resp.aw_ready, 0);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        recv_r(1, 1'b0);
        wait_aw(0);
        wd[0] = 64'h1111;
        write_data(wd, 1, 8'hFF);
        recv_b();

        push_b(4'd3, OKAY);
        push_r(4'd4, 64'h1111, OKAY, 1'b1);
        drive_aw(4'd3, 64'h8000_0188, 8'd0, INCR, 1'b0, 6'd0);
        drive_ar(4'd4, 64'h8000_0180, 8'd0, INCR, 1'b0);
        @(negedge clk);
        check("arb2_aw_ready", resp.aw_ready, 1);
        check("arb2_ar_ready", resp.ar_ready, 0);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        wd[0] = 64'h2222;
        write_data(wd, 1, 8'hFF);
        recv_b();
        wait_ar(0);
        recv_r(1, 1'b0);
        ed[0] = 64'h2222;
        read_txn(4'd5, 64'h8000_0188, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);

        // Exclusive sequence (lock is ignored when the feature is compiled out).
        wd[0] = 64'h55;
        write_txn(4'd1, 64'h8000_0200, 8'd0, INCR, 1'b0, 6'd0, wd, 1, 8'hFF, OKAY);
`ifdef CULSANS_SRAM_EXCL_EN
        ed[0] = 64'h55;
        read_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b1, ed, EXOKAY, 1'b0);
        wd[0] = 64'hABCD;
        write_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b1, 6'd0, wd, 1, 8'hFF, EXOKAY);
        ed[0] = 64'hABCD;
        read_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);
        wd[0] = 64'h9999;
        write_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b1, 6'd0, wd, 1, 8'hFF, OKAY);
        ed[0] = 64'hABCD;
        read_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);
`else
        ed[0] = 64'h55;
        read_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b1, ed, OKAY, 1'b0);
        wd[0] = 64'hABCD;
        write_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b1, 6'd0, wd, 1, 8'hFF, OKAY);
        ed[0] = 64'hABCD;
        read_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);
        wd[0] = 64'h9999;
        write_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b1, 6'd0, wd, 1, 8'hFF, OKAY);
        ed[0] = 64'h9999;
        read_txn(4'd3, 64'h8000_0200, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);
`endif

        // Reset in the middle of a 4-beat read.
        push_r(4'd7, 64'd1, OKAY, 1'b0);
        drive_ar(4'd7, 64'h8000_0100, 8'd3, INCR, 1'b0);
        wait_ar(1);
        recv_r(1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rstmid_r_valid", resp.r_valid, 0);
        check("rstmid_b_valid", resp.b_valid, 0);
        check("rstmid_w_ready", resp.w_ready, 0);
        check("rstmid_r_payload", {resp.r.data, resp.r.last}, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        ed[0] = 64'd2;
        read_txn(4'd8, 64'h8000_0108, 8'd0, INCR, 1'b0, ed, OKAY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
